dt_engine_param: RTL
====================

// Module: dt_engine_param
// PURPOSE
//  Parametrised two-pass distance-transform engine, next generation of the fixed 128x128 DT core.
//  - Reads a packed binary image from the stimulus ROM (sti_*).
//  - Writes per-pixel distances to the result RAM (res_*): forward raster pass, then backward pass.
//  - Adds over the fixed core: configurable image size, ROM word width and pixel width;
//    run-time neighbourhood select (4-neighbour city-block or 8-neighbour chessboard);
//    start-triggered re-runs; saturating distances.
// PARAMETERS
//  IMG_W   128  image width in pixels (>=3)
//  IMG_H   128  image height in pixels (>=3)
//  STI_W   16   stimulus ROM word width, 1 bit per pixel
//  PIX_W   8    result pixel width; distances saturate at 2**PIX_W-1
//  STI_AW  10   sti_addr width, >= clog2(IMG_W*IMG_H/STI_W)
//  RES_AW  14   res_addr width, >= clog2(IMG_W*IMG_H)
// PORTS
//  clk            in   1       clock, all state on posedge
//  reset          in   1       asynchronous, active-low
//  start          in   1       sampled in IDLE only; 1-cycle pulse begins a frame
//  mode           in   1       0 = 4-neighbour, 1 = 8-neighbour; latched when start is accepted
//  busy           out  1       high from the cycle after start until done
//  fwpass_finish  out  1       1-cycle pulse when the forward pass completes
//  done           out  1       1-cycle pulse when the backward pass completes
//  sti_rd         out  1       ROM read enable
//  sti_addr       out  STI_AW  ROM word address
//  sti_di         in   STI_W   ROM data (ROM updates on negedge)
//  res_rd         out  1       RAM read enable
//  res_wr         out  1       RAM write enable
//  res_addr       out  RES_AW  RAM address, shared by read and write
//  res_do         out  PIX_W   RAM write data
//  res_di         in   PIX_W   RAM read data (RAM updates on negedge)
// BEHAVIOUR
//  - Reset (async, reset=0): all outputs 0; FSM to IDLE; latched mode=1; counters cleared. Applies mid-frame.
//  - Pixel mapping:
//      pixel (r,c) has linear index p = r*IMG_W + c;
//      ROM word p/STI_W, bit STI_W-1-(p%STI_W) (MSB-first); RAM address p.
//  - Memory timing:
//      read: assert rd + addr in cycle k; the memory updates on the following negedge;
//            the engine captures sti_di/res_di at posedge k+1.
//      write: res_wr/res_addr/res_do sampled at posedge.
//      res_rd and res_wr are never high in the same cycle.
//  - FSM: IDLE -> FW_FETCH -> FW_RD -> FW_WR -> ... -> FW_END -> BW_RD -> BW_WR -> ... -> DONE -> IDLE.
//  - FW_FETCH: read the next ROM word when the pixel crosses a word boundary; one word buffered.
//  - Forward pass, raster order p = 0 .. IMG_W*IMG_H-1:
//      border pixel (r=0, r=IMG_H-1, c=0, c=IMG_W-1) or background bit: write 0, no reads;
//      object pixel, mode 1: read NW, N, NE, W; write min+1;
//      object pixel, mode 0: read N, W; write min+1.
//  - Forward pass end: fwpass_finish pulses in the cycle after the last write.
//  - Backward pass, reverse order p = IMG_W*IMG_H-1 .. 0:
//      read current pixel; if 0 (background or border), skip with no write;
//      otherwise read SE, S, SW, E (mode 1) or S, E (mode 0);
//      write min(cur, min(nbrs)+1).
//  - Arithmetic: min+1 computed in PIX_W+1 bits, clamped to 2**PIX_W-1; never wraps to 0.
//  - Completion: done pulses 1 cycle after the final backward write/skip, then busy=0 and IDLE.
//  - start while busy: ignored.
//  - start with done in the same cycle: ignored; must be re-issued in IDLE.
//  - mode changes mid-frame: no effect.
// TESTING (IMG_W=IMG_H=8, STI_W=8, PIX_W=8 unless noted; compare full RAM after done)
//  1 Interior all 1, mode 1.
//      Response: rings 1/2/3 from the outside in; border 0; fwpass_finish exactly once, before done.
//  2 Interior all 1 except background at (3,3).
//      Response: (4,4)=1 in mode 1, (4,4)=2 in mode 0; (1,1)=1 in both modes.
//  3 Single object pixel at (3,3), all others 0.
//      Response: RAM[27]=1, all else 0; no res_wr with nonzero data elsewhere.
//  4 PIX_W=2, 16x16, interior all 1, mode 1.
//      Response: centre pixels saturate to 3, ring 1 = 1, ring 2 = 2.
//  5 reset pulled low during the backward pass, then start.
//      Response: outputs 0 immediately; rerun matches scenario 1; done pulses once.
//  6 Back-to-back frames, start asserted while busy.
//      Response: start ignored; second frame (mode 0) starts only from IDLE and gives the correct result.

Source files
------------

// File: rtl/dt_engine_param_if.sv
// Handshake, stimulus-ROM and result-RAM signals of the distance-transform engine.
// The engine side is master; the environment (controller plus memories) is slave.
interface dt_engine_param_if #(
   parameter int unsigned STI_W  = 16,
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned STI_AW = 10,
   parameter int unsigned RES_AW = 14
);
   logic              start;
   logic              mode;
   logic              busy;
   logic              fwpass_finish;
   logic              done;
   logic              sti_rd;
   logic [STI_AW-1:0] sti_addr;
   logic [STI_W-1:0]  sti_di;
   logic              res_rd;
   logic              res_wr;
   logic [RES_AW-1:0] res_addr;
   logic [PIX_W-1:0]  res_do;
   logic [PIX_W-1:0]  res_di;

   modport master (
      input  start, mode, sti_di, res_di,
      output busy, fwpass_finish, done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do
   );

   modport slave (
      output start, mode, sti_di, res_di,
      input  busy, fwpass_finish, done, sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do
   );
endinterface

// File: rtl/dt_engine_param.sv
// Two-pass (forward raster, then reverse raster) distance transform over a packed binary
// image, with selectable 4/8-neighbourhood and distances saturating at the pixel width.
module dt_engine_param #(
   parameter int unsigned IMG_W  = 128,
   parameter int unsigned IMG_H  = 128,
   parameter int unsigned STI_W  = 16,
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned STI_AW = 10,
   parameter int unsigned RES_AW = 14
) (
   input logic              clk,
   input logic              reset,
   dt_engine_param_if.master bus
);
   localparam int unsigned NPIX = IMG_W * IMG_H;
   localparam int unsigned RW   = $clog2(IMG_H);
   localparam int unsigned CW   = $clog2(IMG_W);
   localparam int unsigned BIW  = (STI_W > 1) ? $clog2(STI_W) : 1;
   localparam logic [PIX_W-1:0]  PIX_MAX = '1;
   localparam logic [RES_AW-1:0] LAST_P  = RES_AW'(NPIX - 1);

   typedef enum logic [2:0] {IDLE, FW_FETCH, FW_RD, FW_WR, FW_END, BW_RD, BW_WR, DONE} state_t;

   state_t             state, state_nx;
   logic [RES_AW-1:0]  p, p_nx;
   logic [RW-1:0]      r, r_nx;
   logic [CW-1:0]      c, c_nx;
   logic [BIW-1:0]     bidx, bidx_nx;
   logic [STI_AW-1:0]  waddr, waddr_nx;
   logic [STI_W-1:0]   sti_word, sti_word_nx;
   logic               wvld, wvld_nx;
   logic [2:0]         nb, nb_nx, nb_last;
   logic [PIX_W-1:0]   acc, acc_nx, cur, cur_nx;
   logic               mode_q, mode_nx, rd_cur, rd_cur_nx;
   logic               busy_q, busy_nx, fw_fin_q, fw_fin_nx, done_q, done_nx;
   logic               sti_rd_q, sti_rd_nx, res_rd_q, res_rd_nx, res_wr_q, res_wr_nx;
   logic [STI_AW-1:0]  sti_addr_q, sti_addr_nx;
   logic [RES_AW-1:0]  res_addr_q, res_addr_nx;
   logic [PIX_W-1:0]   res_do_q, res_do_nx;
   logic               fw_adv, bw_adv, border, pix_bit;

   // min+1 in PIX_W+1 bits so an all-ones distance stays all-ones instead of wrapping
   function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] x);
      logic [PIX_W:0] s;
      s = {1'b0, x} + (PIX_W + 1)'(1);
      return s[PIX_W] ? PIX_MAX : s[PIX_W-1:0];
   endfunction

   function automatic logic [PIX_W-1:0] pmin(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

   // Address distance to neighbour k; subtracted in the forward pass, added in the backward pass
   function automatic logic [RES_AW-1:0] nbr_dist(input logic m, input logic [1:0] k);
      logic [RES_AW-1:0] w;
      w = RES_AW'(IMG_W);
      if (!m) return k[0] ? RES_AW'(1) : w;
      case (k)
         2'd0:    return w + RES_AW'(1);
         2'd1:    return w;
         2'd2:    return w - RES_AW'(1);
         default: return RES_AW'(1);
      endcase
   endfunction

   assign bus.busy          = busy_q;
   assign bus.fwpass_finish = fw_fin_q;
   assign bus.done          = done_q;
   assign bus.sti_rd        = sti_rd_q;
   assign bus.sti_addr      = sti_addr_q;
   assign bus.res_rd        = res_rd_q;
   assign bus.res_wr        = res_wr_q;
   assign bus.res_addr      = res_addr_q;
   assign bus.res_do        = res_do_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;      p <= '0;          r <= '0;          c <= '0;
         bidx <= '0;         waddr <= '0;      sti_word <= '0;   wvld <= 1'b0;
         nb <= '0;           acc <= '0;        cur <= '0;        mode_q <= 1'b1;
         rd_cur <= 1'b0;     busy_q <= 1'b0;   fw_fin_q <= 1'b0; done_q <= 1'b0;
         sti_rd_q <= 1'b0;   res_rd_q <= 1'b0; res_wr_q <= 1'b0;
         sti_addr_q <= '0;   res_addr_q <= '0; res_do_q <= '0;
      end else begin
         state <= state_nx;  p <= p_nx;              r <= r_nx;              c <= c_nx;
         bidx <= bidx_nx;    waddr <= waddr_nx;      sti_word <= sti_word_nx; wvld <= wvld_nx;
         nb <= nb_nx;        acc <= acc_nx;          cur <= cur_nx;          mode_q <= mode_nx;
         rd_cur <= rd_cur_nx; busy_q <= busy_nx;     fw_fin_q <= fw_fin_nx;  done_q <= done_nx;
         sti_rd_q <= sti_rd_nx; res_rd_q <= res_rd_nx; res_wr_q <= res_wr_nx;
         sti_addr_q <= sti_addr_nx; res_addr_q <= res_addr_nx; res_do_q <= res_do_nx;
      end
   end

   always_comb begin
      state_nx = state;  p_nx = p;  r_nx = r;  c_nx = c;
      bidx_nx = bidx;  waddr_nx = waddr;  wvld_nx = wvld;  nb_nx = nb;  mode_nx = mode_q;
      // Read data is valid during the cycle its registered read strobe is presented
      sti_word_nx = sti_rd_q ? bus.sti_di : sti_word;
      acc_nx      = (res_rd_q && !rd_cur) ? pmin(acc, bus.res_di) : acc;
      cur_nx      = (res_rd_q && rd_cur) ? bus.res_di : cur;
      rd_cur_nx = 1'b0;  busy_nx = busy_q;  fw_fin_nx = 1'b0;  done_nx = 1'b0;
      sti_rd_nx = 1'b0;  sti_addr_nx = sti_addr_q;
      res_rd_nx = 1'b0;  res_wr_nx = 1'b0;  res_addr_nx = res_addr_q;  res_do_nx = res_do_q;
      fw_adv = 1'b0;  bw_adv = 1'b0;
      nb_last = mode_q ? 3'd3 : 3'd1;
      border  = (r == '0) || (r == RW'(IMG_H - 1)) || (c == '0) || (c == CW'(IMG_W - 1));
      pix_bit = sti_word[BIW'(STI_W - 1) - bidx];

      case (state)
         IDLE: begin
            if (bus.start && !done_q) begin
               mode_nx = bus.mode;  busy_nx = 1'b1;
               p_nx = '0;  r_nx = '0;  c_nx = '0;  bidx_nx = '0;  waddr_nx = '0;
               wvld_nx = 1'b0;  nb_nx = '0;
               state_nx = FW_FETCH;
            end
         end
         FW_FETCH: begin
            if (bidx == '0 && !wvld) begin
               if (sti_rd_q) wvld_nx = 1'b1;
               else begin
                  sti_rd_nx = 1'b1;  sti_addr_nx = waddr;
               end
            end else if (border || !pix_bit) begin
               res_wr_nx = 1'b1;  res_addr_nx = p;  res_do_nx = '0;  fw_adv = 1'b1;
            end else begin
               acc_nx = PIX_MAX;  nb_nx = '0;  state_nx = FW_RD;
            end
         end
         FW_RD: begin
            res_rd_nx = 1'b1;  res_addr_nx = p - nbr_dist(mode_q, nb[1:0]);
            if (nb == nb_last) begin
               nb_nx = '0;  state_nx = FW_WR;
            end else nb_nx = nb + 3'd1;
         end
         FW_WR: begin
            if (!res_rd_q) begin
               res_wr_nx = 1'b1;  res_addr_nx = p;  res_do_nx = sat_inc(acc);  fw_adv = 1'b1;
            end
         end
         FW_END: begin
            fw_fin_nx = 1'b1;  p_nx = LAST_P;  nb_nx = '0;  state_nx = BW_RD;
         end
         BW_RD: begin
            // nb 0: fetch centre; nb 1: wait and test it; nb >= 2: fetch neighbour nb-2
            if (nb == 3'd0) begin
               res_rd_nx = 1'b1;  rd_cur_nx = 1'b1;  res_addr_nx = p;  nb_nx = 3'd1;
            end else if (nb == 3'd1) begin
               if (!res_rd_q) begin
                  if (cur == '0) bw_adv = 1'b1;
                  else begin
                     acc_nx = PIX_MAX;  nb_nx = 3'd2;
                  end
               end
            end else begin
               res_rd_nx = 1'b1;  res_addr_nx = p + nbr_dist(mode_q, 2'(nb - 3'd2));
               if (nb == nb_last + 3'd2) begin
                  nb_nx = '0;  state_nx = BW_WR;
               end else nb_nx = nb + 3'd1;
            end
         end
         BW_WR: begin
            if (!res_rd_q) begin
               res_wr_nx = 1'b1;  res_addr_nx = p;  res_do_nx = pmin(cur, sat_inc(acc));
               bw_adv = 1'b1;
            end
         end
         DONE: begin
            done_nx = 1'b1;  busy_nx = 1'b0;  state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if (fw_adv) begin
         p_nx = p + RES_AW'(1);
         if (c == CW'(IMG_W - 1)) begin
            c_nx = '0;  r_nx = r + RW'(1);
         end else c_nx = c + CW'(1);
         if (bidx == BIW'(STI_W - 1)) begin
            bidx_nx = '0;  waddr_nx = waddr + STI_AW'(1);  wvld_nx = 1'b0;
         end else bidx_nx = bidx + BIW'(1);
         state_nx = (p == LAST_P) ? FW_END : FW_FETCH;
      end

      if (bw_adv) begin
         nb_nx = '0;
         if (p == '0) state_nx = DONE;
         else begin
            p_nx = p - RES_AW'(1);  state_nx = BW_RD;
         end
      end
   end
endmodule
